// File: rtl/block_pack.sv
`timescale 1ns/1ps
// block_pack: packs 2-bit pixel columns into a pair of ROW_WIDTH-bit row words.
// The first accepted column of a row lands at the MSB (leftmost pixel).
// A single registered output slot holds the completed row pair until popped.
// Optional flush support is compiled in with the BLOCK_PACK_FLUSH_EN macro;
// without it the i_flush / o_row_partial ports and all flush logic are absent.
module block_pack #(
    parameter int ROW_WIDTH = 512
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
`ifdef BLOCK_PACK_FLUSH_EN
    input  logic                 i_flush,
    output logic                 o_row_partial,
`endif
    input  logic                 i_col_valid,
    input  logic [1:0]           i_col,
    output logic                 o_col_ready,
    output logic                 o_row_valid,
    output logic [ROW_WIDTH-1:0] o_1st_row_512bit,
    output logic [ROW_WIDTH-1:0] o_2nd_row_512bit,
    input  logic                 i_row_ready
);

    localparam int             CNT_W    = (ROW_WIDTH > 1) ? $clog2(ROW_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(ROW_WIDTH - 1);

    // Accumulation state (columns of the row currently being assembled)
    logic [ROW_WIDTH-1:0] acc1_p0;
    logic [ROW_WIDTH-1:0] acc2_p0;
    logic [CNT_W-1:0]     col_cnt_p0;

    // Output slot
    logic [ROW_WIDTH-1:0] row1_p1;
    logic [ROW_WIDTH-1:0] row2_p1;
    logic                 vld_p1;

    // Accumulators with the current column merged in (used for the in-cycle transfer)
    logic [ROW_WIDTH-1:0] acc1_wr;
    logic [ROW_WIDTH-1:0] acc2_wr;
    logic [CNT_W-1:0]     bit_idx;

    logic last_col;
    logic slot_free;
    logic col_ready;
    logic accept;
    logic pop;
    logic full_xfer;
    logic acc_clear;
    logic slot_load;

    assign last_col  = (col_cnt_p0 == LAST_COL);
    assign slot_free = !vld_p1 || i_row_ready;
    assign accept    = i_col_valid && col_ready;
    assign pop       = vld_p1 && i_row_ready;
    assign full_xfer = accept && last_col;
    // Leftmost pixel first: column k goes to bit ROW_WIDTH-1-k.
    assign bit_idx   = LAST_COL - col_cnt_p0;

`ifdef BLOCK_PACK_FLUSH_EN
    logic flush_pending;
    logic flush_xfer;
    logic flush_drop;
    logic row_partial_p1;

    // A flush only moves data when there is something accumulated and the slot can take it;
    // an empty accumulator just retires the request.
    assign flush_xfer = flush_pending && slot_free && (col_cnt_p0 != '0);
    assign flush_drop = flush_pending && (col_cnt_p0 == '0);
    // The last column of a row may only enter when the slot can take the finished row,
    // which makes ready depend combinationally on i_row_ready.
    assign col_ready  = (!last_col || slot_free) && !flush_pending;
    assign acc_clear  = full_xfer || flush_xfer;
    assign slot_load  = full_xfer || flush_xfer;

    // Flush request latch: set by the pulse, cleared once the flush has been resolved.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            flush_pending <= 1'b0;
        end else if (i_flush) begin
            flush_pending <= 1'b1;
        end else if (flush_xfer || flush_drop) begin
            flush_pending <= 1'b0;
        end
    end

    // Partial-row flag travels with the output slot contents.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            row_partial_p1 <= 1'b0;
        end else if (full_xfer) begin
            row_partial_p1 <= 1'b0;
        end else if (flush_xfer) begin
            row_partial_p1 <= 1'b1;
        end else if (pop) begin
            row_partial_p1 <= 1'b0;
        end
    end

    assign o_row_partial = row_partial_p1;
`else
    // The last column of a row may only enter when the slot can take the finished row,
    // which makes ready depend combinationally on i_row_ready.
    assign col_ready = !last_col || slot_free;
    assign acc_clear = full_xfer;
    assign slot_load = full_xfer;
`endif

    // Merge the incoming column into a copy of the accumulators.
    always_comb begin
        acc1_wr = acc1_p0;
        acc2_wr = acc2_p0;
        if (accept) begin
            acc1_wr[bit_idx] = i_col[1];
            acc2_wr[bit_idx] = i_col[0];
        end
    end

    // ---- stage p0: column accumulation ----
    // Accumulators and column counter: write on accept, clear when the row leaves.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc1_p0    <= '0;
            acc2_p0    <= '0;
            col_cnt_p0 <= '0;
        end else if (acc_clear) begin
            acc1_p0    <= '0;
            acc2_p0    <= '0;
            col_cnt_p0 <= '0;
        end else if (accept) begin
            acc1_p0    <= acc1_wr;
            acc2_p0    <= acc2_wr;
            col_cnt_p0 <= col_cnt_p0 + CNT_W'(1);
        end
    end

    // ---- stage p1: output slot ----
    // Output slot: load on transfer (overrides a simultaneous pop), frozen while held.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            row1_p1 <= '0;
            row2_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (slot_load) begin
            // During a flush no column is accepted, so acc*_wr equals the accumulators.
            row1_p1 <= acc1_wr;
            row2_p1 <= acc2_wr;
            vld_p1  <= 1'b1;
        end else if (pop) begin
            vld_p1  <= 1'b0;
        end
    end

    assign o_col_ready      = col_ready;
    assign o_row_valid      = vld_p1;
    assign o_1st_row_512bit = row1_p1;
    assign o_2nd_row_512bit = row2_p1;

endmodule

// File: doc/block_pack.md
# block_pack

Column-to-row packer for the connected-domain filter's write-back path. It accepts one filtered pixel column per handshake, where a column is one bit for each of two image rows. It assembles the columns into a pair of 512-bit row words, leftmost pixel at bit 511. It is the writer counterpart of the two-row block extraction at the filter input, and its output row pair has the same bit ordering that stage consumes.

## Interface
- ROW_WIDTH, 512: bits per row word; the counter width is derived from it.
- i_clk  input  1  system clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_col_valid  input  1  column valid.
- i_col  input  2  {1st-row bit, 2nd-row bit} for the current column.
- o_col_ready  output  1  column accepted when i_col_valid && o_col_ready.
- o_row_valid  output  1  output row pair valid.
- o_1st_row_512bit  output  ROW_WIDTH  assembled 1st row.
- o_2nd_row_512bit  output  ROW_WIDTH  assembled 2nd row.
- i_row_ready  input  1  row pair consumed when o_row_valid && i_row_ready.
- i_flush  input  1  flush request pulse. Present only with BLOCK_PACK_FLUSH_EN.
- o_row_partial  output  1  set when the current output row pair came from a flush. Present only with BLOCK_PACK_FLUSH_EN.

## Operation
- Storage is two ROW_WIDTH accumulators (acc1, acc2), column counter col_cnt (0..ROW_WIDTH-1) and one output slot (row registers plus o_row_valid).
- Index write on accept:
  - acc1[ROW_WIDTH-1-col_cnt] <= i_col[1]
  - acc2[ROW_WIDTH-1-col_cnt] <= i_col[0]
  - col_cnt increments.
- The first column lands at bit 511. Unwritten bits are always 0.
- slot_free = !o_row_valid || i_row_ready.
- o_col_ready = (col_cnt != ROW_WIDTH-1 || slot_free) && !flush_pending.
  - This is a combinational path from i_row_ready. It is intentional.
- Accepting the column at col_cnt == ROW_WIDTH-1 performs a transfer in the same edge:
  - The completed accumulators, including that column, are copied to the output slot.
  - o_row_valid <= 1.
  - acc1/acc2 are cleared to 0 and col_cnt wraps to 0.
- Output slot rules:
  - Hold: while o_row_valid && !i_row_ready, the slot contents are frozen.
  - Pop: o_row_valid clears on pop unless a transfer happens in the same cycle. In that case, the new data replaces the old and o_row_valid stays 1.
- Reset: all outputs, accumulators and col_cnt go to 0 immediately. o_col_ready is 1 after reset.
  - Reset mid-row discards the partial row.
  - Reset with a pending output discards that output.

## Timing
- Latency: the row pair is valid on the cycle after the edge that accepts the last column.
- Throughput: one column per cycle sustained when i_row_ready stays 1. A full row takes 512 consecutive cycles, with no bubble at the row boundary.
- Back-pressure: if the slot is full and not popping, the 512th column of the next row stalls (o_col_ready=0). Columns 0..510 of the next row are still accepted.
- o_row_valid and the row data are registered. They never change while o_row_valid && !i_row_ready.

## Configuration
- BLOCK_PACK_FLUSH_EN defined:
  - i_flush sets flush_pending. While it is pending, o_col_ready=0.
  - On the first cycle with flush_pending && slot_free && col_cnt != 0:
    - the partial accumulators transfer, left-justified and zero-padded;
    - o_row_partial=1;
    - col_cnt and the accumulators clear;
    - flush_pending clears.
  - If col_cnt == 0 when the flush is evaluated, flush_pending clears with no output.
  - i_flush in the same cycle as an accepted column: the column is written first and is included in the flushed row.
  - A normal full-row transfer sets o_row_partial=0.
- BLOCK_PACK_FLUSH_EN undefined: the i_flush and o_row_partial ports and all flush logic are absent.

## Test plan
- Reset, then 512 columns with alternating i_col 2'b10/2'b01 and i_row_ready=1 -> one cycle after the last accept:
  - o_row_valid=1;
  - o_1st_row_512bit = {256{2'b10}};
  - o_2nd_row_512bit = {256{2'b01}}.
- 1024 back-to-back columns, i_col=2'b11 for row A and 2'b00 for row B, i_row_ready=1 ->
  - o_col_ready stays 1 throughout;
  - two row pairs come out: all-ones, then all-zeros.
- Hold i_row_ready=0 after the first row, then stream 512 more columns ->
  - 511 columns are accepted;
  - o_col_ready=0 at col_cnt=511;
  - the first row stays stable;
  - raising i_row_ready accepts column 511 in that cycle and swaps in the second row with o_row_valid held at 1.
- Single column i_col=2'b10 followed by 511 zeros ->
  - o_1st_row_512bit = 512'h8000…0;
  - o_2nd_row_512bit = 0.
- Assert i_rst after 300 columns, then send 512 columns of 2'b11 -> the output is all-ones in both rows, with no residue from before reset.
- With BLOCK_PACK_FLUSH_EN: 3 columns of 2'b11, then i_flush ->
  - o_row_valid=1 and o_row_partial=1;
  - both rows = {3'b111, 509'b0};
  - a second i_flush with col_cnt=0 produces no output.
